// File: rtl/ntt_pkg.sv
// Shared constants, FSM encoding and address helpers for the NTT bank scheduler.
package ntt_pkg;

  localparam int unsigned LOG_N      = 10;
  localparam int unsigned N_BANKS    = 8;
  localparam int unsigned BANK_DEPTH = 128;
  localparam int unsigned ADDR_W     = LOG_N;
  localparam int unsigned LANES      = N_BANKS;
  localparam int unsigned GROUP_W    = LANES * ADDR_W;
  localparam int unsigned CNT_W      = $clog2(BANK_DEPTH);
  localparam int unsigned STAGE_W    = 4;
  localparam int unsigned BF_W       = LOG_N - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

  // One write-back delay-line slot; last marks the final group of a stage.
  typedef struct packed {
    logic               valid;
    logic               last;
    logic [GROUP_W-1:0] addr;
  } wb_entry_t;

  // Butterfly index j -> lower pair address: a zero bit inserted at position s.
  function automatic logic [ADDR_W-1:0] insert_zero(input logic [BF_W-1:0]    j,
                                                   input logic [STAGE_W-1:0] s);
    logic [ADDR_W-1:0] jw;
    logic [ADDR_W-1:0] mask;
    jw   = ADDR_W'(j);
    mask = (ADDR_W'(1) << s) - ADDR_W'(1);
    return ((jw & ~mask) << 1) | (jw & mask);
  endfunction

endpackage

// File: rtl/ntt_pair_addr_gen.sv
// Combinational lo/hi address pairs for the four butterflies of one issue group.
module ntt_pair_addr_gen
  import ntt_pkg::*;
(
  input  logic [STAGE_W-1:0] stage,
  input  logic [CNT_W-1:0]   cnt,
  output logic [GROUP_W-1:0] addr_group_c
);

  logic [ADDR_W-1:0] lo;
  logic [ADDR_W-1:0] hi;

  // Butterfly j = 4*cnt + k; slot 2k holds lo, slot 2k+1 holds its partner.
  always_comb begin
    addr_group_c = '0;
    lo           = '0;
    hi           = '0;
    for (int k = 0; k < int'(LANES / 2); k++) begin
      lo = insert_zero({cnt, 2'(k)}, stage);
      hi = lo | (ADDR_W'(1) << stage);
      addr_group_c[(2 * k) * ADDR_W +: ADDR_W]     = lo;
      addr_group_c[(2 * k + 1) * ADDR_W +: ADDR_W] = hi;
    end
  end

endmodule

// File: rtl/ntt_bank_scheduler.sv
// Sequences one in-place radix-2 NTT/INTT pass: read-group issue, write-back delay
// line and inter-stage drain so no stage reads ahead of the previous stage's writes.
module ntt_bank_scheduler
  import ntt_pkg::*;
#(
  parameter int unsigned BF_LAT = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                inverse,
  input  logic                dp_ready,
  output logic                busy,
  output logic                done,
  output logic                rd_valid,
  output logic [GROUP_W-1:0]  rd_addr,
  output logic [STAGE_W-1:0]  rd_stage,
  output logic                wr_valid,
  output logic [GROUP_W-1:0]  wr_addr
);

  state_e              state_q;
  state_e              state_d;
  logic [STAGE_W-1:0]  stage_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                inv_q;
  wb_entry_t           wb_q [BF_LAT];
  logic [GROUP_W-1:0]  group_c;
  logic                last_issue_c;
  logic                last_wb_c;
  logic                final_stage_c;

  ntt_pair_addr_gen u_addr_gen (
    .stage        (stage_q),
    .cnt          (cnt_q),
    .addr_group_c (group_c)
  );

  assign last_issue_c  = (state_q == ISSUE) && dp_ready && (cnt_q == CNT_W'(BANK_DEPTH - 1));
  assign last_wb_c     = wb_q[BF_LAT-1].last;
  assign final_stage_c = inv_q ? (stage_q == '0) : (stage_q == STAGE_W'(LOG_N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Drain ends when the stage's last group emerges from the delay line.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)        state_d = ISSUE;
      ISSUE:   if (last_issue_c) state_d = DRAIN;
      DRAIN:   if (last_wb_c)    state_d = final_stage_c ? FINISH : ISSUE;
      FINISH:                    state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == ISSUE) || (state_q == DRAIN);
    done     = (state_q == FINISH);
    rd_valid = (state_q == ISSUE) && dp_ready;
    rd_addr  = ((state_q == ISSUE) && dp_ready) ? group_c : '0;
    rd_stage = ((state_q == ISSUE) && dp_ready) ? stage_q : '0;
  end

  // Stage/group counters; inverse is captured only when a pass is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          inv_q   <= inverse;
          stage_q <= inverse ? STAGE_W'(LOG_N - 1) : '0;
          cnt_q   <= '0;
        end
        ISSUE: if (dp_ready) cnt_q <= cnt_q + CNT_W'(1);
        DRAIN: if (last_wb_c && !final_stage_c)
          stage_q <= inv_q ? stage_q - STAGE_W'(1) : stage_q + STAGE_W'(1);
        default: ;
      endcase
    end
  end

  // Free-running write-back delay line, deliberately not stalled by dp_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BF_LAT); i++) wb_q[i] <= '0;
    end else begin
      wb_q[0] <= {rd_valid, last_issue_c, rd_addr};
      for (int i = 1; i < int'(BF_LAT); i++) wb_q[i] <= wb_q[i-1];
    end
  end

  assign wr_valid = wb_q[BF_LAT-1].valid;
  assign wr_addr  = wb_q[BF_LAT-1].addr;

endmodule
